// File: rtl/seven_seg_scan_ctrl_pkg.sv
// Shared definitions for the 7-segment scan controller: state encodings, anode-off level and a
// width helper.
package seven_seg_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDrive = 2'd1,
    StBlank = 2'd2
  } scan_state_e;

  localparam logic AnodeOff = 1'b1;

  // Bits needed to index n values; never less than 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r = r + 1;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_scan_prescaler.sv
// Loadable down-counter with terminal-count flag; times both the DRIVE and BLANK slots.
module scan_prescaler #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [Width-1:0] loadVal,
  output logic             tc
);

  logic [Width-1:0] cntQ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cntQ <= '0;
    end else if (load) begin
      cntQ <= loadVal;
    end else if (cntQ != '0) begin
      cntQ <= cntQ - 1'b1;
    end
  end

  assign tc = (cntQ == '0);

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode multi-digit 7-segment display.
// Optional macro LEADING_ZERO_BLANK_EN keeps leading-zero digits dark.
module seven_seg_scan_ctrl
  import seven_seg_scan_ctrl_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic [4*NUM_DIGITS-1:0]        digits_bcd,
  input  logic [NUM_DIGITS-1:0]          dp_in,
  output logic [3:0]                     bcd_out,
  output logic                           dp_out,
  output logic [NUM_DIGITS-1:0]          anode,
  output logic [clog2(NUM_DIGITS)-1:0]   digit_idx,
  output logic                           scan_tick
);

  localparam int unsigned IdxW   = clog2(NUM_DIGITS);
  localparam int unsigned MaxCnt = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int unsigned CntW   = clog2(MaxCnt + 1);
  localparam logic [CntW-1:0] DriveLoad = CntW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] BlankLoad = CntW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AllOff = {NUM_DIGITS{AnodeOff}};

  scan_state_e           stateQ;
  logic                  tc, cntLoad;
  logic [CntW-1:0]       cntLoadVal;
  logic [IdxW-1:0]       idxNext, loadIdx;
  logic [3:0]            loadNib;
  logic                  loadDp;
  logic [NUM_DIGITS-1:0] loadAnode, hideMask;

  scan_prescaler #(
    .Width(CntW)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .load   (cntLoad),
    .loadVal(cntLoadVal),
    .tc     (tc)
  );

  always_comb begin
    idxNext = (digit_idx == LastIdx) ? '0 : digit_idx + 1'b1;
    case (stateQ)
      StDrive: loadIdx = idxNext;
      StBlank: loadIdx = digit_idx;
      default: loadIdx = '0;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Digit i>0 is hidden when it and every more-significant nibble are zero.
  logic upperZero;
  always_comb begin
    upperZero = 1'b1;
    hideMask  = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      upperZero   = upperZero & (digits_bcd[4*i +: 4] == 4'd0);
      hideMask[i] = upperZero;
    end
  end
`else
  assign hideMask = '0;
`endif

  always_comb begin
    loadNib   = '0;
    loadDp    = 1'b0;
    loadAnode = AllOff;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (loadIdx == IdxW'(i)) begin
        loadNib      = digits_bcd[4*i +: 4];
        loadDp       = dp_in[i];
        loadAnode[i] = hideMask[i] ? AnodeOff : ~AnodeOff;
      end
    end
  end

  // Prescaler is reloaded on every slot boundary and held at zero while idle or disabled.
  always_comb begin
    cntLoad    = 1'b1;
    cntLoadVal = '0;
    if (en) begin
      case (stateQ)
        StIdle:  cntLoadVal = DriveLoad;
        StDrive: begin
          cntLoad    = tc;
          cntLoadVal = (BLANK_CYCLES > 0) ? BlankLoad : DriveLoad;
        end
        StBlank: begin
          cntLoad    = tc;
          cntLoadVal = DriveLoad;
        end
        default: cntLoadVal = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ    <= StIdle;
      anode     <= AllOff;
      bcd_out   <= '0;
      dp_out    <= 1'b0;
      digit_idx <= '0;
      scan_tick <= 1'b0;
    end else begin
      scan_tick <= 1'b0;
      if (!en) begin
        stateQ    <= StIdle;
        anode     <= AllOff;
        digit_idx <= '0;
      end else begin
        case (stateQ)
          StIdle: begin
            bcd_out   <= loadNib;
            dp_out    <= loadDp;
            anode     <= loadAnode;
            digit_idx <= '0;
            stateQ    <= StDrive;
          end
          StDrive: begin
            if (tc) begin
              scan_tick <= 1'b1;
              digit_idx <= idxNext;
              if (BLANK_CYCLES == 0) begin
                bcd_out <= loadNib;
                dp_out  <= loadDp;
                anode   <= loadAnode;
              end else begin
                anode  <= AllOff;
                stateQ <= StBlank;
              end
            end
          end
          StBlank: begin
            if (tc) begin
              bcd_out <= loadNib;
              dp_out  <= loadDp;
              anode   <= loadAnode;
              stateQ  <= StDrive;
            end
          end
          default: stateQ <= StIdle;
        endcase
      end
    end
  end

  anodeOneHot: assert property (@(posedge clk) disable iff (rst) $onehot0(~anode));

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench: one DUT with a blanking gap, one without, both driven by the same stimulus.
module tb_seven_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [15:0] digits_bcd;
  logic [3:0]  dp_in;

  logic [3:0] bcd1, anode1, bcd2, anode2;
  logic [1:0] idx1, idx2;
  logic       dp1, tick1, dp2, tick2;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic       run;
    logic [7:0] pos;
    logic [1:0] idx;
    logic [3:0] bcd;
    logic       dp;
    logic [3:0] anode;
    logic       tick;
  } mdl_t;

  localparam mdl_t MdlReset = '{run: 1'b0, pos: 8'd0, idx: 2'd0, bcd: 4'd0, dp: 1'b0,
                                anode: 4'hF, tick: 1'b0};

  mdl_t m1, m2;
  mdl_t expQ1[$];
  mdl_t expQ2[$];

  always #5 clk = ~clk;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS(4), .SCAN_DIV(4), .BLANK_CYCLES(2)
  ) u_dut_blank (
    .clk(clk), .rst(rst), .en(en), .digits_bcd(digits_bcd), .dp_in(dp_in),
    .bcd_out(bcd1), .dp_out(dp1), .anode(anode1), .digit_idx(idx1), .scan_tick(tick1)
  );

  seven_seg_scan_ctrl #(
    .NUM_DIGITS(4), .SCAN_DIV(4), .BLANK_CYCLES(0)
  ) u_dut_noblank (
    .clk(clk), .rst(rst), .en(en), .digits_bcd(digits_bcd), .dp_in(dp_in),
    .bcd_out(bcd2), .dp_out(dp2), .anode(anode2), .digit_idx(idx2), .scan_tick(tick2)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic mdl_t mdl_load(mdl_t m, logic [15:0] d, logic [3:0] dpv);
    mdl_t n;
    int   k;
    n = m;
    k = int'(m.idx);
    n.bcd = d[4*k +: 4];
    n.dp = dpv[k];
    n.anode = 4'hF;
    n.anode[k] = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    if (k != 0 && (d >> (4 * k)) == 16'h0) n.anode = 4'hF;
`endif
    return n;
  endfunction

  // Behavioural model: position within the DRIVE+BLANK slot since the last load.
  function automatic mdl_t mdl_step(mdl_t m, int s, int b, logic rstv, logic env,
                                    logic [15:0] d, logic [3:0] dpv);
    mdl_t n;
    int   p;
    if (rstv) return MdlReset;
    n = m;
    n.tick = 1'b0;
    if (!env) begin
      n.run = 1'b0;
      n.pos = 8'd0;
      n.idx = 2'd0;
      n.anode = 4'hF;
      return n;
    end
    if (!m.run) begin
      n.run = 1'b1;
      n.pos = 8'd0;
      n.idx = 2'd0;
      return mdl_load(n, d, dpv);
    end
    p = int'(m.pos) + 1;
    if (p == s) begin
      n.tick = 1'b1;
      n.idx = m.idx + 2'd1;
      n.anode = 4'hF;
    end
    if (p == s + b) begin
      p = 0;
      n = mdl_load(n, d, dpv);
    end
    n.pos = 8'(p);
    return n;
  endfunction

  task automatic compare_all();
    mdl_t e;
    if (expQ1.size() != 0) begin
      e = expQ1.pop_front();
      check_val("blank.anode", 32'(anode1), 32'(e.anode));
      check_val("blank.bcd", 32'(bcd1), 32'(e.bcd));
      check_val("blank.dp", 32'(dp1), 32'(e.dp));
      check_val("blank.idx", 32'(idx1), 32'(e.idx));
      check_val("blank.tick", 32'(tick1), 32'(e.tick));
    end
    if (expQ2.size() != 0) begin
      e = expQ2.pop_front();
      check_val("noblank.anode", 32'(anode2), 32'(e.anode));
      check_val("noblank.bcd", 32'(bcd2), 32'(e.bcd));
      check_val("noblank.dp", 32'(dp2), 32'(e.dp));
      check_val("noblank.idx", 32'(idx2), 32'(e.idx));
      check_val("noblank.tick", 32'(tick2), 32'(e.tick));
    end
  endtask

  // One clock: model sees the same inputs as the DUTs at the edge, outputs checked at negedge.
  task automatic step(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      m1 = mdl_step(m1, 4, 2, rst, en, digits_bcd, dp_in);
      m2 = mdl_step(m2, 4, 0, rst, en, digits_bcd, dp_in);
      expQ1.push_back(m1);
      expQ2.push_back(m2);
      @(negedge clk);
      compare_all();
    end
  endtask

  initial begin
    logic found;
    m1 = MdlReset;
    m2 = MdlReset;
    rst = 1'b1;
    en = 1'b1;
    digits_bcd = 16'h1234;
    dp_in = 4'b0110;

    // Reset held with en high, then released.
    step(2);
    rst = 1'b0;
    step(30);

    // Change inputs mid-DRIVE of digit 1; the held snapshot must not tear.
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (m1.idx == 2'd1 && m1.anode == 4'b1101 && m1.pos == 8'd1) found = 1'b1;
      else step(1);
    end
    check_val("seekDigit1", 32'(found), 32'd1);
    digits_bcd = 16'h9876;
    dp_in = 4'b1001;
    step(30);

    // Drop en during a blanking gap, then re-enable.
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (m1.run && m1.pos >= 8'd4) found = 1'b1;
      else step(1);
    end
    check_val("blankReached", 32'(anode1), 32'hF);
    en = 1'b0;
    step(3);
    en = 1'b1;
    step(20);

    // Asynchronous reset pulse between clock edges.
    #2 rst = 1'b1;
    #1;
    m1 = MdlReset;
    m2 = MdlReset;
    expQ1.push_back(m1);
    expQ2.push_back(m2);
    compare_all();
    #1 rst = 1'b0;
    step(20);

    // Nibbles above 9 pass through; an inner zero digit stays visible.
    digits_bcd = 16'hFA0B;
    dp_in = 4'b1111;
    step(26);

    // Leading-zero patterns.
    digits_bcd = 16'h0050;
    dp_in = 4'b0000;
    step(26);
    digits_bcd = 16'h0000;
    step(26);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
